// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one column per cycle through a single shared column datapath.
// Optional build macro INV_MIX_COLUMNS_SEQ_ADDKEY_EN folds AddRoundKey into the input capture.
module inv_mix_columns_seq (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] state_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} fsm_e;

    fsm_e         r_fsm;
    logic [1:0]   r_cnt;
    logic [127:0] r_work;

    logic [127:0] w_capture;
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;
    logic [127:0] w_work_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each coefficient is built from the x2/x4/x8 doubling chain of the same byte.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        for (int r = 0; r < 4; r++) begin
            res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return res;
    endfunction

`ifdef INV_MIX_COLUMNS_SEQ_ADDKEY_EN
    assign w_capture = state_i ^ key_i;
`else
    logic w_unused_key;
    assign w_unused_key = ^key_i;
    assign w_capture    = state_i;
`endif

    always_comb begin
        w_col_in = r_work[127:96];
        unique case (r_cnt)
            2'd0: w_col_in = r_work[127:96];
            2'd1: w_col_in = r_work[95:64];
            2'd2: w_col_in = r_work[63:32];
            2'd3: w_col_in = r_work[31:0];
        endcase
    end

    assign w_col_out = inv_col(w_col_in);

    always_comb begin
        w_work_next = r_work;
        unique case (r_cnt)
            2'd0: w_work_next[127:96] = w_col_out;
            2'd1: w_work_next[95:64]  = w_col_out;
            2'd2: w_work_next[63:32]  = w_col_out;
            2'd3: w_work_next[31:0]   = w_col_out;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm  <= StIdle;
            r_cnt  <= 2'd0;
            r_work <= '0;
        end else begin
            unique case (r_fsm)
                StIdle: begin
                    if (in_valid_i) begin
                        r_work <= w_capture;
                        r_cnt  <= 2'd0;
                        r_fsm  <= StCalc;
                    end
                end
                StCalc: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_fsm <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        r_fsm <= StIdle;
                    end
                end
                default: r_fsm <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = (r_fsm == StIdle);
    assign out_valid_o = (r_fsm == StDone);
    assign busy_o      = (r_fsm != StIdle);
    assign state_o     = out_valid_o ? r_work : 128'd0;

endmodule
